// File: rtl/jedro_1_mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-port signals around the jedro_1 memory arbiter.
// The arbiter connects to the slave modport. The requesters and memory connect to the master modport.
interface jedro_1_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // instruction fetch port (read only)
    logic                  ifu_req_i;
    logic [DATA_WIDTH-1:0] ifu_addr_i;
    logic                  ifu_gnt_o;
    logic                  ifu_rvalid_o;
    logic [DATA_WIDTH-1:0] ifu_rdata_o;

    // load/store port
    logic                  lsu_req_i;
    logic                  lsu_we_i;
    logic [BE_WIDTH-1:0]   lsu_be_i;
    logic [DATA_WIDTH-1:0] lsu_addr_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;
    logic                  lsu_gnt_o;
    logic                  lsu_rvalid_o;
    logic [DATA_WIDTH-1:0] lsu_rdata_o;

    // single-port memory, one-cycle read latency
    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  ifu_req_i, ifu_addr_i,
        output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
        input  lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
        output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
        output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output ifu_req_i, ifu_addr_i,
        input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o,
        output lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
        input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
        input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/jedro_1_mem_arbiter.sv
// Two-requester arbiter (IFU, LSU) in front of a single-port, one-cycle-latency memory.
// The LSU has priority. The IFU is forced through after MAX_DATA_BURST LSU wins while it waits.
module jedro_1_mem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input logic                    clk_i,
    input logic                    rst_i,
    jedro_1_mem_arbiter_if.slave   bus
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_BURST);

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_e;

    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_next;
    logic             r_rsp_pending;
    owner_e           r_rsp_owner;

    logic                  w_starved;
    logic                  w_ifu_gnt;
    logic                  w_lsu_gnt;
    logic                  w_mem_en;
    logic                  w_mem_we;
    logic [BE_W-1:0]       w_mem_be;
    logic [DATA_WIDTH-1:0] w_mem_addr;

    // Grants are combinational and gated by reset so that nothing reaches memory while held in reset.
    always_comb begin
        w_starved = (r_starve_cnt == CNT_MAX);
        w_ifu_gnt = ~rst_i & bus.ifu_req_i & (~bus.lsu_req_i | w_starved);
        w_lsu_gnt = ~rst_i & bus.lsu_req_i & ~w_ifu_gnt;
        w_mem_en  = w_ifu_gnt | w_lsu_gnt;
        w_mem_we  = w_lsu_gnt & bus.lsu_we_i;
        w_mem_addr = w_ifu_gnt ? bus.ifu_addr_i : bus.lsu_addr_i;
    end

    // Instruction fetches always read whole words. LSU byte enables only matter on its own grant.
    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_be_lane
            assign w_mem_be[gi] = w_ifu_gnt | (w_lsu_gnt & bus.lsu_be_i[gi]);
        end
    endgenerate

    // The starvation count runs only while the IFU is actually waiting behind LSU grants.
    always_comb begin
        w_starve_next = r_starve_cnt;
        if (w_ifu_gnt || !bus.ifu_req_i) begin
            w_starve_next = '0;
        end else if (w_lsu_gnt && !w_starved) begin
            w_starve_next = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_starve_cnt  <= '0;
            r_rsp_pending <= 1'b0;
            r_rsp_owner   <= OWNER_IFU;
        end else begin
            r_starve_cnt  <= w_starve_next;
            r_rsp_pending <= w_mem_en & ~w_mem_we;
            if (w_mem_en) begin
                r_rsp_owner <= w_ifu_gnt ? OWNER_IFU : OWNER_LSU;
            end
        end
    end

    assign bus.ifu_gnt_o   = w_ifu_gnt;
    assign bus.lsu_gnt_o   = w_lsu_gnt;
    assign bus.mem_en_o    = w_mem_en;
    assign bus.mem_we_o    = w_mem_we;
    assign bus.mem_be_o    = w_mem_be;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_wdata_o = bus.lsu_wdata_i;

    // Read data is shared. Only the owner's rvalid qualifies it.
    assign bus.ifu_rvalid_o = r_rsp_pending & (r_rsp_owner == OWNER_IFU);
    assign bus.lsu_rvalid_o = r_rsp_pending & (r_rsp_owner == OWNER_LSU);
    assign bus.ifu_rdata_o  = bus.mem_rdata_i;
    assign bus.lsu_rdata_o  = bus.mem_rdata_i;

    a_single_grant : assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_ifu_gnt && w_lsu_gnt));
    a_starve_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        r_starve_cnt <= CNT_MAX);
endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Randomized and directed checks of jedro_1_mem_arbiter against a behavioural memory/arbitration model.
module tb_jedro_1_mem_arbiter;
    localparam int DW    = 32;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] tb_mem  [0:255];
    logic [31:0] ref_mem [0:255];

    jedro_1_mem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    jedro_1_mem_arbiter #(.DATA_WIDTH(DW), .MAX_DATA_BURST(BURST)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // memory attached to the arbiter: byte-masked writes, one-cycle registered reads
    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be_o[b]) tb_mem[bus.mem_addr_o[9:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
            end else begin
                bus.mem_rdata_i <= tb_mem[bus.mem_addr_o[9:2]];
            end
        end
    end

    task automatic idle();
        bus.ifu_req_i = 1'b0; bus.ifu_addr_i = '0;
        bus.lsu_req_i = 1'b0; bus.lsu_we_i = 1'b0; bus.lsu_be_i = '0;
        bus.lsu_addr_i = '0;  bus.lsu_wdata_i = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.ifu_req_i = 1'b1; bus.lsu_req_i = 1'b1;
        #1;
        checks++;
        if (bus.ifu_gnt_o !== 1'b0 || bus.lsu_gnt_o !== 1'b0 || bus.mem_en_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_grants: ifu_gnt=%b lsu_gnt=%b mem_en=%b, required all 0", bus.ifu_gnt_o, bus.lsu_gnt_o, bus.mem_en_o);
        end
        @(negedge clk);
        checks++;
        if (bus.ifu_rvalid_o !== 1'b0 || bus.lsu_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_rvalid: ifu_rvalid=%b lsu_rvalid=%b, required 0 0", bus.ifu_rvalid_o, bus.lsu_rvalid_o);
        end
        rst = 1'b0; bus.lsu_req_i = 1'b0; bus.ifu_addr_i = 32'h0;
        #1;
        checks++;
        if (bus.ifu_gnt_o !== 1'b1 || bus.mem_en_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: ifu_gnt=%b mem_en=%b, required 1 1", bus.ifu_gnt_o, bus.mem_en_o);
        end
        @(negedge clk);
        checks++;
        if (bus.ifu_rvalid_o !== 1'b1 || bus.ifu_rdata_o !== ref_mem[0]) begin
            errors++;
            $display("FAIL reset_first_rsp: ifu_rvalid=%b rdata=%h, required 1 %h", bus.ifu_rvalid_o, bus.ifu_rdata_o, ref_mem[0]);
        end
        idle();
        $display("test_reset: first IFU read after reset returned %h", bus.ifu_rdata_o);
    endtask

    task automatic test_ifu_seq();
        logic [31:0] words [3];
        for (int i = 0; i < 3; i++) begin
            words[i] = $urandom; tb_mem[i] = words[i]; ref_mem[i] = words[i];
        end
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (bus.ifu_rvalid_o !== 1'b1 || bus.lsu_rvalid_o !== 1'b0 || bus.ifu_rdata_o !== words[i-1]) begin
                    errors++;
                    $display("FAIL ifu_seq_rsp%0d: ifu_rvalid=%b lsu_rvalid=%b rdata=%h, required 1 0 %h", i-1, bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.ifu_rdata_o, words[i-1]);
                end
            end
            if (i < 3) begin
                bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'(i * 4);
                #1;
                checks++;
                if (bus.ifu_gnt_o !== 1'b1 || bus.mem_en_o !== 1'b1 || bus.mem_we_o !== 1'b0 ||
                    bus.mem_addr_o !== 32'(i * 4) || bus.mem_be_o !== 4'hF) begin
                    errors++;
                    $display("FAIL ifu_seq_gnt%0d: gnt=%b en=%b we=%b addr=%h be=%h, required 1 1 0 %h f", i, bus.ifu_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_be_o, 32'(i * 4));
                end
                $display("test_ifu_seq: IFU read addr=%h", 32'(i * 4));
            end else begin
                idle();
            end
        end
        @(negedge clk);
        checks++;
        if (bus.ifu_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL ifu_seq_drain: ifu_rvalid=%b, required 0", bus.ifu_rvalid_o);
        end
    endtask

    task automatic test_burst_pattern();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'($urandom_range(0, 63)) << 2;
            bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = 32'($urandom_range(0, 63)) << 2;
            #1;
            checks++;
            if (bus.ifu_gnt_o !== ((i % 5) == 4) || bus.lsu_gnt_o !== ((i % 5) != 4)) begin
                errors++;
                $display("FAIL burst_pattern%0d: ifu_gnt=%b lsu_gnt=%b, required %b %b", i, bus.ifu_gnt_o, bus.lsu_gnt_o, (i % 5) == 4, (i % 5) != 4);
            end
            checks++;
            if (bus.ifu_rvalid_o === 1'b1 && bus.lsu_rvalid_o === 1'b1) begin
                errors++;
                $display("FAIL burst_rvalid_overlap%0d: both rvalids 1, required at most one", i);
            end
            $display("test_burst_pattern: cycle %0d grant %s", i, bus.ifu_gnt_o ? "IFU" : "LSU");
        end
        @(negedge clk);
        idle();
        @(negedge clk);
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b1; bus.lsu_be_i = 4'b0011;
        bus.lsu_addr_i = 32'h100; bus.lsu_wdata_i = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.lsu_gnt_o !== 1'b1 || bus.mem_we_o !== 1'b1 || bus.mem_be_o !== 4'b0011 ||
            bus.mem_addr_o !== 32'h100 || bus.mem_wdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_gnt: gnt=%b we=%b be=%b addr=%h wdata=%h, required 1 1 0011 100 deadbeef", bus.lsu_gnt_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
        ref_mem[64][15:0] = 16'hBEEF;
        $display("test_write_read: LSU write addr=100 data=deadbeef be=0011");
        @(negedge clk);
        checks++;
        if (bus.lsu_rvalid_o !== 1'b0 || bus.ifu_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_no_rvalid: lsu_rvalid=%b ifu_rvalid=%b, required 0 0", bus.lsu_rvalid_o, bus.ifu_rvalid_o);
        end
        bus.lsu_we_i = 1'b0; bus.lsu_be_i = 4'hF;
        #1;
        checks++;
        if (bus.lsu_gnt_o !== 1'b1 || bus.mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_gnt: gnt=%b we=%b, required 1 0", bus.lsu_gnt_o, bus.mem_we_o);
        end
        @(negedge clk);
        checks++;
        if (bus.lsu_rvalid_o !== 1'b1 || bus.lsu_rdata_o !== 32'h0000BEEF) begin
            errors++;
            $display("FAIL rd_rsp: lsu_rvalid=%b rdata=%h, required 1 0000beef", bus.lsu_rvalid_o, bus.lsu_rdata_o);
        end
        $display("test_write_read: LSU read addr=100 data=%h", bus.lsu_rdata_o);
        idle();
        @(negedge clk);
        checks++;
        if (bus.lsu_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_drain: lsu_rvalid=%b, required 0", bus.lsu_rvalid_o);
        end
    endtask

    task automatic test_ifu_then_lsu();
        @(negedge clk);
        bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'h8;
        #1;
        checks++;
        if (bus.ifu_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL order_ifu_gnt: ifu_gnt=%b, required 1", bus.ifu_gnt_o);
        end
        @(negedge clk);
        checks++;
        if (bus.ifu_rvalid_o !== 1'b1 || bus.lsu_rvalid_o !== 1'b0 || bus.ifu_rdata_o !== ref_mem[2]) begin
            errors++;
            $display("FAIL order_ifu_rsp: ifu_rvalid=%b lsu_rvalid=%b rdata=%h, required 1 0 %h", bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.ifu_rdata_o, ref_mem[2]);
        end
        idle();
        bus.lsu_req_i = 1'b1; bus.lsu_addr_i = 32'h4;
        #1;
        checks++;
        if (bus.lsu_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL order_lsu_gnt: lsu_gnt=%b, required 1", bus.lsu_gnt_o);
        end
        @(negedge clk);
        checks++;
        if (bus.ifu_rvalid_o !== 1'b0 || bus.lsu_rvalid_o !== 1'b1 || bus.lsu_rdata_o !== ref_mem[1]) begin
            errors++;
            $display("FAIL order_lsu_rsp: ifu_rvalid=%b lsu_rvalid=%b rdata=%h, required 0 1 %h", bus.ifu_rvalid_o, bus.lsu_rvalid_o, bus.lsu_rdata_o, ref_mem[1]);
        end
        idle();
        $display("test_ifu_then_lsu: IFU addr=8 then LSU addr=4");
        @(negedge clk);
    endtask

    task automatic test_reset_outstanding();
        // three LSU wins while the IFU waits, then a reset in the middle of a fourth
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'h20;
            bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = 32'h10;
            #1;
            checks++;
            if (bus.lsu_gnt_o !== 1'b1 || bus.ifu_gnt_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_pre_lsu%0d: lsu_gnt=%b ifu_gnt=%b, required 1 0", i, bus.lsu_gnt_o, bus.ifu_gnt_o);
            end
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.lsu_gnt_o !== 1'b0 || bus.ifu_gnt_o !== 1'b0 || bus.mem_en_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_grants: lsu_gnt=%b ifu_gnt=%b mem_en=%b, required 0 0 0", bus.lsu_gnt_o, bus.ifu_gnt_o, bus.mem_en_o);
        end
        @(negedge clk);
        checks++;
        if (bus.ifu_rvalid_o !== 1'b0 || bus.lsu_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_rvalid: ifu_rvalid=%b lsu_rvalid=%b, required 0 0", bus.ifu_rvalid_o, bus.lsu_rvalid_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.lsu_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_post_first: lsu_gnt=%b, required 1", bus.lsu_gnt_o);
        end
        // a cleared starvation count gives four LSU wins before the IFU
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.ifu_gnt_o !== (i == 4) || bus.lsu_gnt_o !== (i != 4)) begin
                errors++;
                $display("FAIL rst_post_pattern%0d: ifu_gnt=%b lsu_gnt=%b, required %b %b", i, bus.ifu_gnt_o, bus.lsu_gnt_o, i == 4, i != 4);
            end
        end
        @(negedge clk);
        bus.lsu_req_i = 1'b0;
        #1;
        checks++;
        if (bus.ifu_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_ifu_gnt: ifu_gnt=%b, required 1", bus.ifu_gnt_o);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ifu_rvalid_o !== 1'b0 || bus.lsu_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_ifu_drop: ifu_rvalid=%b lsu_rvalid=%b, required 0 0", bus.ifu_rvalid_o, bus.lsu_rvalid_o);
        end
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (bus.ifu_rvalid_o !== 1'b0 || bus.lsu_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_ifu_after: ifu_rvalid=%b lsu_rvalid=%b, required 0 0", bus.ifu_rvalid_o, bus.lsu_rvalid_o);
        end
        $display("test_reset_outstanding: reset dropped outstanding responses");
    endtask

    task automatic test_random();
        bit          ifu_pend = 0, lsu_pend = 0;
        logic [31:0] ifu_a = '0, lsu_a = '0, lsu_wd = '0;
        logic        lsu_w = 1'b0;
        logic [3:0]  lsu_b = '0;
        bit          exp_ifu_rv = 0, exp_lsu_rv = 0, exp_ifu_g, exp_lsu_g;
        logic [31:0] exp_rd = '0;
        int          waits = 0;   // LSU wins since the IFU was last served while it waited
        for (int cyc = 0; cyc <= 400; cyc++) begin
            @(negedge clk);
            checks++;
            if (bus.ifu_rvalid_o !== exp_ifu_rv || bus.lsu_rvalid_o !== exp_lsu_rv) begin
                errors++;
                $display("FAIL rand_rvalid@%0d: ifu_rvalid=%b lsu_rvalid=%b, required %b %b", cyc, bus.ifu_rvalid_o, bus.lsu_rvalid_o, exp_ifu_rv, exp_lsu_rv);
            end
            if (exp_ifu_rv || exp_lsu_rv) begin
                checks++;
                if ((exp_ifu_rv ? bus.ifu_rdata_o : bus.lsu_rdata_o) !== exp_rd) begin
                    errors++;
                    $display("FAIL rand_rdata@%0d: rdata=%h, required %h", cyc, exp_ifu_rv ? bus.ifu_rdata_o : bus.lsu_rdata_o, exp_rd);
                end
            end
            if (cyc == 400) break;
            if (!ifu_pend && $urandom_range(0, 3) != 0) begin
                ifu_pend = 1; ifu_a = 32'($urandom_range(0, 63)) << 2;
            end
            if (!lsu_pend && $urandom_range(0, 3) != 0) begin
                lsu_pend = 1; lsu_w = 1'($urandom_range(0, 1)); lsu_b = 4'($urandom);
                lsu_a = 32'($urandom_range(0, 63)) << 2; lsu_wd = $urandom;
            end
            bus.ifu_req_i = ifu_pend; bus.ifu_addr_i = ifu_a;
            bus.lsu_req_i = lsu_pend; bus.lsu_we_i = lsu_w; bus.lsu_be_i = lsu_b;
            bus.lsu_addr_i = lsu_a; bus.lsu_wdata_i = lsu_wd;
            exp_ifu_g = ifu_pend && (!lsu_pend || waits == BURST);
            exp_lsu_g = lsu_pend && !exp_ifu_g;
            #1;
            checks++;
            if (bus.ifu_gnt_o !== exp_ifu_g || bus.lsu_gnt_o !== exp_lsu_g || bus.mem_en_o !== (exp_ifu_g || exp_lsu_g)) begin
                errors++;
                $display("FAIL rand_gnt@%0d: ifu_gnt=%b lsu_gnt=%b en=%b, required %b %b %b", cyc, bus.ifu_gnt_o, bus.lsu_gnt_o, bus.mem_en_o, exp_ifu_g, exp_lsu_g, exp_ifu_g || exp_lsu_g);
            end
            checks++;
            if (exp_ifu_g) begin
                if (bus.mem_addr_o !== ifu_a || bus.mem_we_o !== 1'b0 || bus.mem_be_o !== 4'hF) begin
                    errors++;
                    $display("FAIL rand_ifu_port@%0d: addr=%h we=%b be=%h, required %h 0 f", cyc, bus.mem_addr_o, bus.mem_we_o, bus.mem_be_o, ifu_a);
                end
            end else if (exp_lsu_g) begin
                if (bus.mem_addr_o !== lsu_a || bus.mem_we_o !== lsu_w || bus.mem_be_o !== lsu_b ||
                    (lsu_w && bus.mem_wdata_o !== lsu_wd)) begin
                    errors++;
                    $display("FAIL rand_lsu_port@%0d: addr=%h we=%b be=%h wdata=%h, required %h %b %h %h", cyc, bus.mem_addr_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o, lsu_a, lsu_w, lsu_b, lsu_wd);
                end
            end else if (bus.mem_we_o !== 1'b0) begin
                errors++;
                $display("FAIL rand_idle_we@%0d: mem_we=%b, required 0", cyc, bus.mem_we_o);
            end
            exp_ifu_rv = exp_ifu_g;
            exp_lsu_rv = exp_lsu_g && !lsu_w;
            if (exp_ifu_g) exp_rd = ref_mem[ifu_a[9:2]];
            else if (exp_lsu_g && !lsu_w) exp_rd = ref_mem[lsu_a[9:2]];
            if (exp_lsu_g && lsu_w)
                for (int b = 0; b < 4; b++)
                    if (lsu_b[b]) ref_mem[lsu_a[9:2]][8*b +: 8] = lsu_wd[8*b +: 8];
            if (exp_ifu_g || !ifu_pend) waits = 0;
            else if (exp_lsu_g && waits < BURST) waits++;
            if (exp_ifu_g) $display("test_random: cycle %0d IFU read addr=%h", cyc, ifu_a);
            if (exp_lsu_g) $display("test_random: cycle %0d LSU %s addr=%h be=%h wdata=%h", cyc, lsu_w ? "write" : "read", lsu_a, lsu_b, lsu_wd);
            if (exp_ifu_g) ifu_pend = 0;
            if (exp_lsu_g) lsu_pend = 0;
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = '0; ref_mem[i] = '0;
        end
        bus.mem_rdata_i = '0;
        idle();
        test_reset();
        test_ifu_seq();
        test_burst_pattern();
        test_write_read();
        test_ifu_then_lsu();
        test_reset_outstanding();
        test_random();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jedro_1_mem_arbiter.md
JEDRO_1_MEM_ARBITER -- requirements
Module: jedro_1_mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data and address bus width.
REQ-002 The block SHALL have parameter MAX_DATA_BURST, default 4, meaning the maximum consecutive LSU grants while an IFU request waits.
REQ-003 The block SHALL have port clk_i  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  meaning the reset, which is asynchronous and active-high.
REQ-005 The block SHALL have port ifu_req_i  input  1  meaning the IFU read request.
REQ-006 The block SHALL have port ifu_addr_i  input  DATA_WIDTH  meaning the IFU read address.
REQ-007 The block SHALL have port ifu_gnt_o  output  1  meaning the IFU request is accepted this cycle.
REQ-008 The block SHALL have port ifu_rvalid_o  output  1  meaning ifu_rdata_o is valid.
REQ-009 The block SHALL have port ifu_rdata_o  output  DATA_WIDTH  meaning the IFU read data.
REQ-010 The block SHALL have port lsu_req_i  input  1  meaning the LSU access request.
REQ-011 The block SHALL have port lsu_we_i  input  1  meaning write (1) or read (0).
REQ-012 The block SHALL have port lsu_be_i  input  DATA_WIDTH/8  meaning the write byte enables.
REQ-013 The block SHALL have port lsu_addr_i  input  DATA_WIDTH  meaning the LSU address.
REQ-014 The block SHALL have port lsu_wdata_i  input  DATA_WIDTH  meaning the LSU write data.
REQ-015 The block SHALL have port lsu_gnt_o  output  1  meaning the LSU request is accepted this cycle.
REQ-016 The block SHALL have port lsu_rvalid_o  output  1  meaning lsu_rdata_o is valid (reads only).
REQ-017 The block SHALL have port lsu_rdata_o  output  DATA_WIDTH  meaning the LSU read data.
REQ-018 The block SHALL have ports mem_en_o, mem_we_o (1), mem_be_o (DATA_WIDTH/8), mem_addr_o, mem_wdata_o (DATA_WIDTH) as outputs, and mem_rdata_i (DATA_WIDTH) as an input, forming a single-port memory with one-cycle read latency.

Function
REQ-019 Grants SHALL be combinational in the request cycle; mem_en_o = ifu_gnt_o | lsu_gnt_o, and at most one grant is high per cycle.
REQ-020 Priority: the LSU SHALL win when both request, except when starve_cnt == MAX_DATA_BURST, in which case the IFU wins.
REQ-021 starve_cnt (width clog2(MAX_DATA_BURST+1)) SHALL increment on an LSU grant with ifu_req_i high, clear on an IFU grant or when ifu_req_i is low, and never exceed MAX_DATA_BURST.
REQ-022 On an IFU grant the block SHALL drive mem_addr_o=ifu_addr_i, mem_we_o=0, and mem_be_o all ones.
REQ-023 On an LSU grant the block SHALL pass lsu_we_i, lsu_be_i, lsu_addr_i, and lsu_wdata_i through to the memory port.
REQ-024 With no grant, the block SHALL hold mem_en_o=0 and mem_we_o=0.
REQ-025 The block SHALL register the response owner (IFU/LSU) and the read flag each cycle a grant occurs; rsp_pending_q = mem_en_o & ~mem_we_o.
REQ-026 ifu_rvalid_o SHALL be 1 exactly one cycle after an IFU grant; lsu_rvalid_o SHALL be 1 exactly one cycle after an LSU read grant; an LSU write SHALL produce no rvalid.
REQ-027 ifu_rdata_o and lsu_rdata_o SHALL both equal mem_rdata_i; only the rvalid signals qualify them.
REQ-028 Requesters SHALL NOT backpressure; a new grant in the cycle its response returns is allowed (full throughput, 1 access/cycle).
REQ-029 The interface SHALL treat a request not granted as held by the requester with stable fields; the block stores no request.
REQ-030 Addresses SHALL pass through unmodified; no alignment check is performed.

Reset
REQ-031 While rst_i=1 the block SHALL assert: starve_cnt=0, rsp_pending_q=0, all grants=0, mem_en_o=0, ifu_rvalid_o=0, lsu_rvalid_o=0.
REQ-032 A reset asserted with a response outstanding SHALL drop that response (no rvalid after deassert).
REQ-033 After deassert the first grant SHALL be possible in the first clock cycle.

Verification
REQ-034 IFU-only reads, addresses 0x0,0x4,0x8 on consecutive cycles -> gnt each cycle; ifu_rvalid_o high on cycles +1..+3 with the matching memory words.
REQ-035 IFU and LSU both request continuously, MAX_DATA_BURST=4 -> grant pattern LSU,LSU,LSU,LSU,IFU repeating.
REQ-036 LSU write of 0xDEADBEEF with be=4'b0011 to 0x100, then an LSU read of 0x100 -> no rvalid for the write; the read returns 0x0000BEEF (memory initially 0); lsu_rvalid_o high one cycle after the read grant only.
REQ-037 IFU read granted at cycle N, LSU read granted at N+1 -> ifu_rvalid_o only at N+1 and lsu_rvalid_o only at N+2; the rvalids are never high together.
REQ-038 Assert rst_i for one cycle while an IFU read is outstanding -> rvalids stay 0, starve_cnt=0, and the next request is granted immediately after deassert.
